// File: rtl/handshake_constant_seq_pkg.sv
// Shared definitions for the handshake constant sequencer: FSM encoding
// and the width helper used to size the table pointer and burst counter.
package handshake_constant_seq_pkg;

    // Output channel is either empty or presenting a token.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Bits needed to index n items; a degenerate n of 1 still needs one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : handshake_constant_seq_pkg

// File: rtl/handshake_constant_seq.sv
// Handshake constant sequencer: each accepted ctrl token starts a burst of
// REPEAT output tokens read round-robin from the INIT table. The table
// pointer persists across bursts, so consecutive bursts walk the table.
module handshake_constant_seq
    import handshake_constant_seq_pkg::*;
#(
    parameter int                          DATA_WIDTH = 32,
    parameter int                          DEPTH      = 4,
    parameter int                          REPEAT     = 1,
    parameter logic [DEPTH*DATA_WIDTH-1:0] INIT       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);

    localparam int PTR_W = width_of(DEPTH);
    localparam int REM_W = width_of(REPEAT);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(REPEAT - 1);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_outs;
    logic [PTR_W-1:0]        r_ptr;
    logic [REM_W-1:0]        r_remaining;

    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   w_next_outs;
    logic [PTR_W-1:0]        w_next_ptr;
    logic [REM_W-1:0]        w_next_remaining;

    logic [DATA_WIDTH-1:0]   w_table_word;
    logic [PTR_W-1:0]        w_ptr_inc;
    logic                    w_ctrl_fire;
    logic                    w_out_fire;

    assign outs_valid = (r_state == EMIT);
    assign outs       = r_outs;
    assign outs_last  = outs_valid && (r_remaining == '0);

    // A new burst may start when nothing is pending or the last token of
    // the current burst leaves this very cycle.
    assign ctrl_ready = !outs_valid || (outs_ready && outs_last);

    assign w_ctrl_fire = ctrl_valid && ctrl_ready;
    assign w_out_fire  = outs_valid && outs_ready;

    assign w_table_word = INIT[int'(r_ptr) * DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_inc    = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;

    // Next-state: start a burst on ctrl accept, advance within a burst on an
    // output handshake, fall back to IDLE once the last token is taken.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        w_next_state     = r_state;
        w_next_outs      = r_outs;
        w_next_ptr       = r_ptr;
        w_next_remaining = r_remaining;

        if (w_ctrl_fire) begin
            w_next_state     = EMIT;
            w_next_outs      = w_table_word;
            w_next_ptr       = w_ptr_inc;
            w_next_remaining = REM_LOAD;
        end else if (w_out_fire) begin
            if (outs_last) begin
                w_next_state = IDLE;
            end else begin
                w_next_outs      = w_table_word;
                w_next_ptr       = w_ptr_inc;
                w_next_remaining = r_remaining - 1'b1;
            end
        end
    end

    // State register with synchronous reset taking priority over handshakes.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= IDLE;
            r_outs      <= '0;
            r_ptr       <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_next_state;
            r_outs      <= w_next_outs;
            r_ptr       <= w_next_ptr;
            r_remaining <= w_next_remaining;
        end
    end

endmodule : handshake_constant_seq

// File: doc/handshake_constant_seq.md
HANDSHAKE_CONSTANT_SEQ -- requirements
Module: handshake_constant_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each emitted constant.
REQ-002 SHALL have parameter DEPTH, default 4: number of table entries; legal range 1..256.
REQ-003 SHALL have parameter REPEAT, default 1: output tokens emitted per accepted ctrl token; legal range 1..65535.
REQ-004 SHALL have parameter INIT, default all-zero, width DEPTH*DATA_WIDTH: packed table; entry k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-005 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port ctrl_valid  input  1: control token offered.
REQ-008 SHALL have port ctrl_ready  output  1: block accepts control token.
REQ-009 SHALL have port outs  output  DATA_WIDTH: current constant.
REQ-010 SHALL have port outs_valid  output  1: outs holds a valid token.
REQ-011 SHALL have port outs_ready  input  1: consumer accepts token.
REQ-012 SHALL have port outs_last  output  1: high with the final token of each burst.

Function
REQ-013 SHALL transfer a token on any channel only in a cycle where valid and ready are both high.
REQ-014 SHALL hold state IDLE (outs_valid=0) or EMIT (outs_valid=1); no other states.
REQ-015 SHALL drive ctrl_ready = !outs_valid || (outs_ready && outs_last), combinationally.
REQ-016 SHALL, on ctrl accept, register outs <= table[ptr], ptr <= ptr+1 mod DEPTH, remaining <= REPEAT-1, outs_valid <= 1; first output is visible one cycle after ctrl accept.
REQ-017 SHALL drive outs_last = outs_valid && (remaining == 0).
REQ-018 SHALL, on an output handshake with remaining != 0, register outs <= table[ptr], ptr <= ptr+1 mod DEPTH, and decrement remaining, with no bubble cycle.
REQ-019 SHALL, on an output handshake with outs_last=1 and no ctrl accept in the same cycle, return to IDLE (outs_valid <= 0).
REQ-020 SHALL, on a last-token handshake coinciding with a ctrl accept, apply REQ-016 in that cycle so that outs_valid stays 1 (back-to-back bursts at full throughput).
REQ-021 SHALL keep outs, outs_last and outs_valid stable while outs_valid=1 and outs_ready=0.
REQ-022 SHALL wrap ptr from DEPTH-1 to 0; ptr is not reset between bursts, so consecutive bursts continue through the table.
REQ-023 SHALL, with DEPTH=1, always emit INIT; with REPEAT=1, assert outs_last on every token.
REQ-024 SHALL size ptr as max(1,clog2(DEPTH)) bits and remaining as max(1,clog2(REPEAT)) bits; no arithmetic on outs.

Reset
REQ-025 SHALL, while rst=1, force outs_valid=0, outs=0, ptr=0, remaining=0, state IDLE; rst takes priority over any handshake in the same cycle.
REQ-026 SHALL, on rst asserted mid-burst, discard the remaining tokens; the first token after reset comes from entry 0.
REQ-027 SHALL drive ctrl_ready=1 and outs_last=0 during and immediately after reset.

Structure
REQ-028 SHALL place the state encoding (IDLE, EMIT) and the clog2-based width helpers in a shared handshake package.
REQ-029 SHALL be one flat module; table lookup is an indexed part-select of INIT, with no sub-module.

Verification (DATA_WIDTH=8, DEPTH=3, INIT entries 0x11,0x22,0x33)
REQ-030 SHALL check REPEAT=1, outs_ready=1, four ctrl tokens back-to-back -> outs 0x11,0x22,0x33,0x11 on consecutive cycles, outs_last=1 on each, ctrl_ready never low.
REQ-031 SHALL check REPEAT=2, one ctrl token, outs_ready=1 -> 0x11 (last=0), 0x22 (last=1), then outs_valid=0; ctrl_ready low during the first output cycle.
REQ-032 SHALL check REPEAT=2 with outs_ready held low 3 cycles on the first token -> outs stays 0x11, outs_last=0, ctrl_ready=0 throughout the stall.
REQ-033 SHALL check REPEAT=2, ctrl_valid high continuously -> output stream 0x11,0x22,0x33,0x11 with last pattern 0,1,0,1 and no bubble.
REQ-034 SHALL check rst pulsed after the first output of a REPEAT=2 burst -> next cycle outs_valid=0; the next ctrl token yields 0x11.
REQ-035 SHALL check DEPTH=1, INIT=0xA5, REPEAT=3 -> 0xA5 three times, outs_last only on the third.
